axi_rd_slave_responder: RTL and testbench

// AXI4 read-side slave endpoint that sits behind one sN_* port of the read-channel slave switch.

---
 rtl/axi_rd_slave_responder.sv | 116 +++++++++++
 tb/tb_axi_rd_slave_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave_responder.sv
// axi_rd_slave_responder: AXI4 read slave serving FIXED/INCR/WRAP bursts from a preloadable word memory
module axi_rd_slave_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int RESP_WIDTH = 2,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         sys_clk,
  input  logic                         sys_rstn,
  input  logic [ID_WIDTH-1:0]          s_arid,
  input  logic [ADDR_WIDTH-1:0]        s_araddr,
  input  logic [7:0]                   s_arlen,
  input  logic [2:0]                   s_arsize,
  input  logic [1:0]                   s_arburst,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [ID_WIDTH-1:0]          s_rid,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic [RESP_WIDTH-1:0]        s_rresp,
  output logic                         s_rlast,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);
  localparam int BYTES_W = $clog2(DATA_WIDTH / 8);
  localparam int MEM_AW  = $clog2(MEM_DEPTH);
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_BURST = 1'b1;
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_ar_align;
  logic                  w_ar_err;
  logic [MEM_AW-1:0]     w_ar_idx;
  logic [MEM_AW-1:0]     w_next_idx;

  // Next beat address for the latched burst; error bursts never use the data so their address is don't-care
  always_comb begin
    w_bytes     = ADDR_WIDTH'(1) << r_size;
    w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    w_next_addr = r_burst == 2'b01 ? r_addr + w_bytes :
                  r_burst == 2'b10 ? (r_addr & ~w_wrap_mask) | ((r_addr + w_bytes) & w_wrap_mask) :
                  r_addr;
    w_next_idx  = w_next_addr[BYTES_W +: MEM_AW];
  end

  // Classify the incoming request; any illegal field turns the whole burst into SLVERR
  always_comb begin
    w_ar_align = s_araddr & ((ADDR_WIDTH'(1) << s_arsize) - ADDR_WIDTH'(1));
    w_ar_idx   = s_araddr[BYTES_W +: MEM_AW];
    w_ar_err   = s_arburst == 2'b11 || 32'(s_arsize) > BYTES_W ||
                 (s_arburst == 2'b10 && !(s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                 (s_arburst == 2'b10 && w_ar_align != '0);
  end

  // Preload port; not reset so contents survive a mid-burst reset
  always_ff @(posedge sys_clk)
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;

  // Request acceptance and beat sequencing; data is sampled from memory as each beat loads
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      r_state   <= S_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rid     <= '0;
      s_rdata   <= '0;
      s_rresp   <= '0;
    end else if (r_state == S_IDLE) begin
      if (s_arready && s_arvalid) begin
        r_state   <= S_BURST;
        s_arready <= 1'b0;
        s_rvalid  <= 1'b1;
        s_rid     <= s_arid;
        r_addr    <= s_araddr;
        r_len     <= s_arlen;
        r_size    <= s_arsize;
        r_burst   <= s_arburst;
        r_err     <= w_ar_err;
        r_cnt     <= 8'd0;
        s_rlast   <= s_arlen == 8'd0;
        s_rresp   <= w_ar_err ? SLVERR : '0;
        s_rdata   <= w_ar_err ? '0 : r_mem[w_ar_idx];
      end else begin
        s_arready <= 1'b1;
      end
    end else if (s_rvalid && s_rready) begin
      if (s_rlast) begin
        r_state   <= S_IDLE;
        s_rvalid  <= 1'b0;
        s_rlast   <= 1'b0;
        s_arready <= 1'b1;
      end else begin
        r_addr  <= w_next_addr;
        r_cnt   <= r_cnt + 8'd1;
        s_rlast <= r_cnt + 8'd1 == r_len;
        s_rdata <= r_err ? '0 : r_mem[w_next_idx];
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_slave_responder.sv
// tb_axi_rd_slave_responder: scoreboard bench for the AXI read slave responder
module tb_axi_rd_slave_responder;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        sys_clk = 0;
  logic        sys_rstn = 0;
  logic [3:0]  s_arid = 0;
  logic [31:0] s_araddr = 0;
  logic [7:0]  s_arlen = 0;
  logic [2:0]  s_arsize = 0;
  logic [1:0]  s_arburst = 0;
  logic        s_arvalid = 0;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1;
  logic        mem_we = 0;
  logic [7:0]  mem_waddr = 0;
  logic [31:0] mem_wdata = 0;

  logic [31:0] tb_mem [256];
  beat_t       q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  axi_rd_slave_responder dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input int size, input logic [1:0] burst);
    logic [31:0] a;
    logic [31:0] bytes;
    logic [31:0] bnd;
    bit          err;
    beat_t       b;
    a = addr;
    bytes = 32'd1 << size;
    bnd = (len + 1) * bytes;
    err = burst == 2'b11 || size > 2 || (burst == 2'b10 && !(len inside {1, 3, 7, 15})) ||
          (burst == 2'b10 && (addr % bytes) != 0);
    for (int i = 0; i <= len; i++) begin
      b.id = id;
      b.data = err ? 32'h0 : tb_mem[(a >> 2) % 256];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = i == len;
      q.push_back(b);
      if (burst == 2'b01) a = a + bytes;
      else if (burst == 2'b10 && !err) a = (a / bnd) * bnd + (a + bytes) % bnd;
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arvalid = 1;
    while (s_arready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    n_checks++;
    if (n == 50) begin
      n_fail++;
      $display("FAIL ar_accept: arready=%b after %0d cycles, required 1", s_arready, n);
    end
    @(negedge sys_clk);
    s_arvalid = 0;
  endtask

  task automatic drain(input string name, input logic [3:0] pat, input int plen, input int npop);
    int    k;
    int    pops;
    int    guard;
    beat_t e;
    beat_t o;
    k = 0; pops = 0; guard = 0;
    while (q.size() > 0 && pops != npop && guard < 100) begin
      s_rready = pat[k % plen];
      if (s_rvalid === 1'b1) begin
        e = q[0];
        o = {s_rid, s_rdata, s_rresp, s_rlast};
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s beat %0d: got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                   name, pops, o.id, o.data, o.resp, o.last, e.id, e.data, e.resp, e.last);
        end
        if (s_rready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      k++;
      guard++;
      @(negedge sys_clk);
    end
    n_checks++;
    if (guard == 100) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats outstanding, required 0", name, q.size());
    end
    if (q.size() == 0) begin
      n_checks++;
      if (s_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s extra_beat: rvalid=%b, required 0", name, s_rvalid);
      end
    end
    s_rready = 1;
  endtask

  task automatic test_reset();
    sys_rstn = 0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({s_arready, s_rvalid, s_rlast, s_rid, s_rdata, s_rresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b, required all 0",
               s_arready, s_rvalid, s_rlast, s_rid, s_rdata, s_rresp);
    end
    sys_rstn = 1;
    @(negedge sys_clk);
    n_checks++;
    if (s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_arready: got %b, required 1", s_arready);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 256; i++) begin
      mem_we = 1; mem_waddr = 8'(i); mem_wdata = 32'h100 + i;
      @(negedge sys_clk);
      tb_mem[i] = 32'h100 + i;
    end
    mem_we = 0;
    push_burst(4'd5, 32'h0, 3, 2, 2'b01);
    send_ar(4'd5, 32'h0, 8'd3, 3'd2, 2'b01);
    n_checks++;
    if (s_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL incr_latency: rvalid=%b one cycle after AR, required 1", s_rvalid);
    end
    drain("incr", 4'b0001, 1, -1);
  endtask

  task automatic test_wrap_fixed();
    push_burst(4'd1, 32'h8, 3, 2, 2'b10);
    send_ar(4'd1, 32'h8, 8'd3, 3'd2, 2'b10);
    drain("wrap", 4'b0001, 1, -1);
    push_burst(4'd2, 32'h4, 2, 2, 2'b00);
    send_ar(4'd2, 32'h4, 8'd2, 3'd2, 2'b00);
    drain("fixed", 4'b0001, 1, -1);
  endtask

  task automatic test_stall();
    push_burst(4'd3, 32'h10, 1, 2, 2'b01);
    send_ar(4'd3, 32'h10, 8'd1, 3'd2, 2'b01);
    drain("stall", 4'b1100, 4, -1);
  endtask

  task automatic test_slverr();
    push_burst(4'd4, 32'h0, 1, 2, 2'b11);
    send_ar(4'd4, 32'h0, 8'd1, 3'd2, 2'b11);
    drain("err_reserved", 4'b0001, 1, -1);
    push_burst(4'd6, 32'h0, 2, 2, 2'b10);
    send_ar(4'd6, 32'h0, 8'd2, 3'd2, 2'b10);
    drain("err_wraplen", 4'b0001, 1, -1);
  endtask

  task automatic test_reset_mid();
    push_burst(4'd10, 32'h20, 7, 2, 2'b01);
    send_ar(4'd10, 32'h20, 8'd7, 3'd2, 2'b01);
    drain("mid_pre", 4'b0001, 1, 2);
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== tb_mem[10]) begin
      n_fail++;
      $display("FAIL mid_beat2: rvalid=%b rdata=%h, required 1 %h", s_rvalid, s_rdata, tb_mem[10]);
    end
    sys_rstn = 0;
    @(negedge sys_clk);
    n_checks++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b0 || s_rlast !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rvalid=%b arready=%b rlast=%b, required 0 0 0", s_rvalid, s_arready, s_rlast);
    end
    sys_rstn = 1;
    q.delete();
    @(negedge sys_clk);
    n_checks++;
    if (s_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release_arready: got %b, required 1", s_arready);
    end
    push_burst(4'd11, 32'h30, 3, 2, 2'b01);
    send_ar(4'd11, 32'h30, 8'd3, 3'd2, 2'b01);
    drain("mid_after", 4'b0001, 1, -1);
  endtask

  task automatic test_back_to_back();
    int n;
    push_burst(4'd7, 32'h40, 1, 2, 2'b01);
    push_burst(4'd8, 32'h0, 0, 2, 2'b00);
    s_arid = 4'd7; s_araddr = 32'h40; s_arlen = 8'd1; s_arsize = 3'd2; s_arburst = 2'b01; s_arvalid = 1;
    n = 0;
    while (s_arready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    s_arid = 4'd8; s_araddr = 32'h0; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'b00;
    n_checks++;
    if (s_arready !== 1'b0 || s_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_accept: arready=%b rvalid=%b, required 0 1", s_arready, s_rvalid);
    end
    drain("b2b_a", 4'b0001, 1, 2);
    n_checks++;
    if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: arready=%b rvalid=%b, required 1 0", s_arready, s_rvalid);
    end
    mem_we = 1; mem_waddr = 8'd0; mem_wdata = 32'hDEADBEEF;
    @(negedge sys_clk);
    mem_we = 0;
    s_arvalid = 0;
    tb_mem[0] = 32'hDEADBEEF;
    drain("b2b_b_olddata", 4'b0001, 1, -1);
    push_burst(4'd9, 32'h0, 0, 2, 2'b00);
    send_ar(4'd9, 32'h0, 8'd0, 3'd2, 2'b00);
    drain("b2b_newdata", 4'b0001, 1, -1);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_stall();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
